// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch path.
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam int         WORD_BYTES = 4;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection for an accepted instruction:
// jump beats taken branch, which beats sequential.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        pcsrc_i,
    input  logic        jump_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] pcplus4;
    logic [31:0] imm_ext;
    logic [31:0] btarget;
    logic [31:0] jtarget;
    logic        unused_opcode;

    assign pcplus4 = pc_i + 32'(WORD_BYTES);
    assign imm_ext = sext16(instr_i[15:0]);
    assign btarget = pcplus4 + (imm_ext << 2);
    assign jtarget = {pcplus4[31:28], instr_i[25:0], 2'b00};

    assign unused_opcode = ^instr_i[31:26];

    always_comb begin
        next_pc_o = pcplus4;
        priority case (1'b1)
            jump_i:  next_pc_o = jtarget;
            pcsrc_i: next_pc_o = btarget;
            default: next_pc_o = pcplus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: one outstanding imem read,
// instruction held for decode until accepted, then PC advance.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WIDTH    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] imem_addr,
    output logic             imem_req,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             pcsrc,
    input  logic             jump,
    output logic [31:0]      fetch_count
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] ipc_q, ipc_d;
    logic             valid_q, valid_d;
    logic [31:0]      count_q, count_d;
    logic [WIDTH-1:0] next_pc;
    logic             accept;

    next_pc_calc u_next_pc (
        .pc_i      (pc_q),
        .instr_i   (instr_q),
        .pcsrc_i   (pcsrc),
        .jump_i    (jump),
        .next_pc_o (next_pc)
    );

    assign accept = valid_q & instr_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        count_d = count_q;
        unique case (state_q)
            FETCH: begin
                if (imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    valid_d = 1'b0;
                    count_d = count_q + 32'd1;
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Request is gated by reset so it drops the moment reset asserts.
    assign imem_req    = reset & (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign fetch_count = count_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch sequencer on the producing end of the control interface.
- Holds the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Presents each fetched instruction (op/funct/imm fields) to the decode/control stage with a valid/ready handshake.
- Takes back pcsrc and jump for the accepted instruction and computes the next PC (branch, jump or sequential).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- WIDTH, 32, address/instruction width; only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- imem_addr  output  32  word address of the current fetch; bits [1:0] always 0.
- imem_req  output  1  fetch request; held high until imem_gnt.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  fetched instruction.
- instr  output  32  instruction presented to decode.
- instr_pc  output  32  PC of the presented instruction.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts instr this cycle.
- pcsrc  input  1  branch taken for the instruction being accepted; sampled only on accept.
- jump  input  1  jump for the instruction being accepted; sampled only on accept.
- fetch_count  output  32  number of accepted instructions; wraps modulo 2^32.

Behaviour:
- Reset (asynchronous, reset=0):
  - pc=RESET_PC, state=FETCH.
  - imem_req=0, instr=0, instr_pc=0, instr_valid=0, fetch_count=0.
  - First imem_req=1 is driven in the first cycle after reset deasserts.
- FSM states: FETCH, WAIT, HOLD. At most one request is outstanding.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_gnt=1 -> WAIT.
  - imem_rvalid in FETCH is stale and ignored.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 -> register instr=imem_rdata, instr_pc=pc, instr_valid=1, go to HOLD.
  - rvalid in the same cycle as gnt is not supported: memory latency is at least 1 cycle after gnt.
- HOLD:
  - instr_valid=1. instr and instr_pc stay stable until accepted.
  - Accept = instr_valid & instr_ready.
  - On accept:
    - instr_valid=0.
    - fetch_count+=1.
    - pc=next_pc.
    - Go to FETCH.
  - Minimum instruction period is 3 cycles (FETCH, WAIT, HOLD) with gnt and rvalid one cycle apart.
- next_pc is computed from the accepted instruction:
  - pcplus4 = pc+4, wraps 32'hFFFF_FFFC -> 0.
  - btarget = pcplus4 + (signext(instr[15:0]) << 2), mod 2^32.
  - jtarget = {pcplus4[31:28], instr[25:0], 2'b00}.
  - Priority: jump=1 -> jtarget; else pcsrc=1 -> btarget; else pcplus4. jump wins if both are 1.
- pcsrc and jump are ignored when no accept occurs.
- Reset mid-operation (any state): everything returns to reset values immediately. A late rvalid from the abandoned request that arrives in FETCH is discarded.
- imem_addr equals pc in all states.

Decomposition:
- Shared package (mips_pkg):
  - fetch_state_t enum {FETCH, WAIT, HOLD}.
  - Constants OP_BEQ=6'b000100, OP_BNE=6'b000101, OP_J=6'b000010, WORD_BYTES=4.
- One natural sub-module, next_pc_calc: combinational pcplus4/btarget/jtarget plus the priority mux.
- FSM and registers live in fetch_unit.

Test Plan:
- Sequential fetch: RESET_PC=0; memory grants immediately, rvalid 1 cycle after gnt; ready=1; pcsrc=jump=0 -> instr_pc 0x0, 0x4, 0x8, 0xC in order, one instruction per 3 cycles, fetch_count=4.
- Branch taken: instr 0x1000_0003 (beq, imm=3) at pc 0x10 accepted with pcsrc=1 -> next imem_addr=0x20. Same with imm=0xFFFF -> 0x10.
- Jump: instr 0x0800_0040 at pc 0x4000_0000 accepted with jump=1 and pcsrc=1 -> next imem_addr=0x4000_0100 (jump priority).
- Backpressure: ready=0 for 5 cycles in HOLD, with pcsrc toggling meanwhile -> instr/instr_pc stable, no new imem_req, fetch_count unchanged. Ready=1 with pcsrc=0 -> pc+4.
- Delays and wrap: gnt delayed 4 cycles -> imem_req held with constant imem_addr. pc=0xFFFF_FFFC accepted -> next imem_addr=0x0.
- Mid-operation reset: reset=0 asserted in WAIT -> outputs at reset values immediately. A stale rvalid after release, while in FETCH -> ignored, instr_valid stays 0, next fetch from RESET_PC.
